mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port program/data RAM between the CPU control/datapath and the front-panel host loader/checker.
- Ownership follows cpustate:
  - IN (2'b00): host writes.
  - CHECK (2'b01): host reads back.
  - RUN (2'b11): CPU memory cycles.
  - 2'b10: no owner.
- Sequences each RAM access through a fixed 3-state handshake and holds read data until the next completion.
- Keeps the host's sequential address pointer.

Parameters:
AW, 8, address width
DW, 8, data width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
cpustate  in  2  CPU mode: 00 IN, 01 CHECK, 11 RUN, 10 idle
cpu_read  in  1  CPU read request, held until cpu_ack
cpu_write  in  1  CPU write request, held until cpu_ack
cpu_addr  in  AW  CPU address (from AR)
cpu_wdata  in  DW  CPU write data (bus)
cpu_rdata  out  DW  CPU read data, held register
cpu_ack  out  1  one-cycle completion pulse
cpu_stall  out  1  CPU request pending and not yet acked
host_req  in  1  host access request, held until host_ack
host_wdata  in  DW  switch data for IN-mode writes
host_ptr_clr  in  1  synchronous clear of host pointer
host_ptr  out  AW  current host address
host_rdata  out  DW  CHECK-mode read data, held register
host_ack  out  1  one-cycle completion pulse
mem_cs  out  1  RAM select
mem_we  out  1  RAM write enable
mem_addr  out  AW  RAM address
mem_din  out  DW  RAM write data
mem_dout  in  DW  RAM read data, synchronous: valid the cycle after the address is sampled

Behaviour:
- Reset (rst low, async):
  - state IDLE.
  - All outputs 0: mem_cs, mem_we, mem_addr, mem_din, cpu_ack, host_ack, cpu_rdata, host_rdata, host_ptr.
  - cpu_stall follows its combinational definition.
- Owner decode (in IDLE only, from live cpustate):
  - 00 → HOST_WR.
  - 01 → HOST_RD.
  - 11 → CPU.
  - 10 → NONE.
- States: IDLE, ACC, LAT.
- Cycle N, IDLE, request from the current owner:
  - Latch address, data, direction and owner id into the mem_* output registers and the owner register.
  - Go to ACC.
  - CPU address = cpu_addr. Host address = host_ptr.
  - CPU direction: write if cpu_write, read if cpu_read. cpu_read and cpu_write both high → write wins.
- N+1, ACC:
  - mem_cs=1; mem_we=1 only for writes.
  - Go to LAT.
- N+2, LAT:
  - mem_cs=0, mem_we=0.
  - Reads: capture mem_dout into the owner's rdata register at the end of the cycle.
  - Set the owner's ack for the next cycle.
  - Go to IDLE.
- N+3: ack pulses high for one cycle; rdata is valid and held until the next read completes.
  - The FSM is back in IDLE.
  - A still-held request is not re-accepted in N+3 (ack suppression), so a new access earliest starts at N+4.
- Latency: 3 cycles request→ack. One access in flight at most.
- Host pointer:
  - Increments by 1 in the cycle host_ack is high.
  - Wraps 2^AW-1 → 0.
  - host_ptr_clr forces 0 and has priority over increment.
- cpu_stall = (cpu_read|cpu_write) & ~cpu_ack.
  - Stays high indefinitely when the CPU is not owner.
- Requests from a non-owner are ignored with no side effects; requests under NONE are ignored.
- cpustate change during ACC/LAT: the in-flight access completes under the latched owner (ack, rdata, pointer increment all as normal). The new owner takes effect at the next IDLE.
- Async reset mid-access: abort immediately, no ack, RAM write suppressed from reset assertion.

Decomposition:
- Shared package:
  - cpustate encodings: ST_IN=2'b00, ST_CHECK=2'b01, ST_RUN=2'b11.
  - FSM encodings: IDLE, ACC, LAT.
  - Owner ids: NONE, CPU, HOST.
- No sub-module; a single flat FSM plus pointer counter.

Test Plan:
- IN mode:
  - Stimulus: ptr_clr, then host_req with wdata 8'h12, 8'h34, 8'h56.
  - Response: mem_we pulses at addresses 0, 1, 2 with matching din; host_ack 3 cycles after each accept; host_ptr ends at 3.
- CHECK mode:
  - Stimulus: after ptr_clr, host_req with the RAM model pre-loaded at 0 with 8'h12.
  - Response: host_rdata = 8'h12 at ack; no mem_we; ptr = 1.
- RUN mode:
  - Stimulus: cpu_read at addr 8'h02 (RAM 8'h56).
  - Response: cpu_stall high for 3 cycles; cpu_ack in N+3; cpu_rdata = 8'h56, held after the request drops.
- Ownership:
  - Stimulus 1: cpustate=11 with host_req high.
  - Response 1: no mem_cs, no host_ack.
  - Stimulus 2: cpustate=00 with cpu_write high.
  - Response 2: cpu_stall stays high, no write.
- Mode switch mid-access:
  - Stimulus: host write accepted in IN, cpustate→11 during ACC.
  - Response: host write completes with host_ack; a pending cpu_read is accepted in the next IDLE.
- Pointer wrap and reset:
  - Stimulus 1: ptr at 8'hFF, write.
  - Response 1: ptr → 8'h00.
  - Stimulus 2: rst low during ACC of a write.
  - Response 2: mem_we drops immediately, all outputs 0, no ack.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the RAM port arbiter: CPU mode, FSM states, owner ids.
package mem_port_arbiter_pkg;

  // CPU mode as presented on cpustate; 2'b10 leaves the RAM without an owner
  typedef enum logic [1:0] {
    ST_IN    = 2'b00,
    ST_CHECK = 2'b01,
    ST_NONE  = 2'b10,
    ST_RUN   = 2'b11
  } cpustate_e;

  // Access sequencer: select in ACC, data returns in LAT
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC  = 2'b01,
    LAT  = 2'b10
  } fsm_e;

  // Who the in-flight access belongs to
  typedef enum logic [1:0] {
    NONE = 2'b00,
    CPU  = 2'b01,
    HOST = 2'b10
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the arbiter, the CPU, the host loader and the RAM.
interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic [1:0]    cpustate;
  logic          cpu_read;
  logic          cpu_write;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          cpu_stall;
  logic          host_req;
  logic [DW-1:0] host_wdata;
  logic          host_ptr_clr;
  logic [AW-1:0] host_ptr;
  logic [DW-1:0] host_rdata;
  logic          host_ack;
  logic          mem_cs;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  // Arbiter side
  modport slave (
    input  cpustate, cpu_read, cpu_write, cpu_addr, cpu_wdata,
    input  host_req, host_wdata, host_ptr_clr, mem_dout,
    output cpu_rdata, cpu_ack, cpu_stall, host_ptr, host_rdata, host_ack,
    output mem_cs, mem_we, mem_addr, mem_din
  );

  // CPU / host / RAM side
  modport master (
    output cpustate, cpu_read, cpu_write, cpu_addr, cpu_wdata,
    output host_req, host_wdata, host_ptr_clr, mem_dout,
    input  cpu_rdata, cpu_ack, cpu_stall, host_ptr, host_rdata, host_ack,
    input  mem_cs, mem_we, mem_addr, mem_din
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between CPU (RUN) and front-panel host (IN/CHECK).
// Each access: accept in IDLE, select in ACC, capture in LAT, ack next cycle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  fsm_e          state_q, state_d;
  owner_e        owner_q, owner_d;
  logic          wr_q, wr_d;
  logic          cs_q, cs_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          host_ack_q, host_ack_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          accept;

  // State and output registers; reset aborts any access and drops the RAM strobe at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= NONE;
      wr_q         <= 1'b0;
      cs_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
      cpu_ack_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
      ptr_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      wr_q         <= wr_d;
      cs_q         <= cs_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      cpu_ack_q    <= cpu_ack_d;
      host_ack_q   <= host_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
      ptr_q        <= ptr_d;
    end
  end

  // Next-state: owner decode and accept in IDLE, strobe in ACC, capture and ack in LAT
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    wr_d         = wr_q;
    cs_d         = 1'b0;
    we_d         = 1'b0;
    addr_d       = addr_q;
    din_d        = din_q;
    cpu_ack_d    = 1'b0;
    host_ack_d   = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    accept       = 1'b0;

    case (state_q)
      IDLE: begin
        // A request still held during its own ack cycle is not taken again
        case (cpustate_e'(bus.cpustate))
          ST_RUN: if ((bus.cpu_read || bus.cpu_write) && !cpu_ack_q) begin
            accept  = 1'b1;
            owner_d = CPU;
            wr_d    = bus.cpu_write;
            addr_d  = bus.cpu_addr;
            din_d   = bus.cpu_wdata;
          end
          ST_IN: if (bus.host_req && !host_ack_q) begin
            accept  = 1'b1;
            owner_d = HOST;
            wr_d    = 1'b1;
            addr_d  = ptr_q;
            din_d   = bus.host_wdata;
          end
          ST_CHECK: if (bus.host_req && !host_ack_q) begin
            accept  = 1'b1;
            owner_d = HOST;
            wr_d    = 1'b0;
            addr_d  = ptr_q;
            din_d   = bus.host_wdata;
          end
          default: ;
        endcase
        if (accept) begin
          cs_d    = 1'b1;
          we_d    = wr_d;
          state_d = ACC;
        end
      end
      ACC: state_d = LAT;
      LAT: begin
        // Completion goes to the latched owner even if cpustate moved meanwhile
        if (owner_q == CPU) begin
          cpu_ack_d = 1'b1;
          if (!wr_q) cpu_rdata_d = bus.mem_dout;
        end else if (owner_q == HOST) begin
          host_ack_d = 1'b1;
          if (!wr_q) host_rdata_d = bus.mem_dout;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Host address pointer: clear beats the post-ack increment, wraps naturally
  always_comb begin
    ptr_d = ptr_q;
    if (bus.host_ptr_clr)  ptr_d = '0;
    else if (host_ack_q)   ptr_d = ptr_q + AW'(1);
  end

  assign bus.mem_cs     = cs_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_din    = din_q;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.host_ack   = host_ack_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.host_rdata = host_rdata_q;
  assign bus.host_ptr   = ptr_q;
  assign bus.cpu_stall  = (bus.cpu_read | bus.cpu_write) & ~cpu_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a synchronous RAM model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(8), .DW(8)) bus ();

  mem_port_arbiter #(.AW(8), .DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM model: read data valid the cycle after the address is sampled
  logic [7:0] ram [0:255] = '{default: 8'h00};
  logic       pre_we   = 1'b0;
  logic [7:0] pre_addr = 8'h00;
  logic [7:0] pre_data = 8'h00;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (bus.mem_cs) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
      bus.mem_dout <= ram[bus.mem_addr];
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic clr_ptr;
    bus.host_ptr_clr = 1'b1;
    @(negedge clk);
    bus.host_ptr_clr = 1'b0;
  endtask

  task automatic test_reset;
    bus.cpustate = 2'b10; bus.cpu_read = 1'b1; bus.cpu_write = 1'b0;
    bus.cpu_addr = 8'h00; bus.cpu_wdata = 8'h00; bus.host_req = 1'b0;
    bus.host_wdata = 8'h00; bus.host_ptr_clr = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.mem_cs, bus.mem_we, bus.mem_addr, bus.mem_din, bus.cpu_ack, bus.host_ack,
         bus.cpu_rdata, bus.host_rdata, bus.host_ptr} !== 44'h0) begin
      miscompares++; $display("FAIL reset_outputs got cs=%b we=%b addr=%h din=%h ptr=%h exp all 0",
        bus.mem_cs, bus.mem_we, bus.mem_addr, bus.mem_din, bus.host_ptr);
    end
    vectors++;
    if (bus.cpu_stall !== 1'b1) begin
      miscompares++; $display("FAIL reset_stall got %b exp 1", bus.cpu_stall);
    end
    bus.cpu_read = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_in_mode;
    logic [7:0] wd [3] = '{8'h12, 8'h34, 8'h56};
    bus.cpustate = 2'b00;
    clr_ptr();
    vectors++;
    if (bus.host_ptr !== 8'h00) begin
      miscompares++; $display("FAIL in_clr got %h exp 00", bus.host_ptr);
    end
    for (int i = 0; i < 3; i++) begin
      bus.host_wdata = wd[i]; bus.host_req = 1'b1;
      @(negedge clk);
      vectors++;
      if ({bus.mem_cs, bus.mem_we, bus.mem_addr, bus.mem_din, bus.host_ack} !== {2'b11, 8'(i), wd[i], 1'b0}) begin
        miscompares++; $display("FAIL in_acc%0d got cs=%b we=%b addr=%h din=%h ack=%b exp 1 1 %h %h 0",
          i, bus.mem_cs, bus.mem_we, bus.mem_addr, bus.mem_din, bus.host_ack, 8'(i), wd[i]);
      end
      @(negedge clk);
      vectors++;
      if ({bus.mem_cs, bus.mem_we, bus.host_ack} !== 3'b000) begin
        miscompares++; $display("FAIL in_lat%0d got cs=%b we=%b ack=%b exp 0 0 0", i, bus.mem_cs, bus.mem_we, bus.host_ack);
      end
      @(negedge clk);
      vectors++;
      if (bus.host_ack !== 1'b1) begin
        miscompares++; $display("FAIL in_ack%0d got %b exp 1", i, bus.host_ack);
      end
      bus.host_req = 1'b0;
      @(negedge clk);
      vectors++;
      if ({bus.host_ack, bus.host_ptr, ram[i]} !== {1'b0, 8'(i + 1), wd[i]}) begin
        miscompares++; $display("FAIL in_done%0d got ack=%b ptr=%h ram=%h exp 0 %h %h",
          i, bus.host_ack, bus.host_ptr, ram[i], 8'(i + 1), wd[i]);
      end
    end
  endtask

  task automatic test_check_mode;
    bus.cpustate = 2'b01;
    preload(8'h00, 8'h12);
    clr_ptr();
    bus.host_req = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.mem_cs, bus.mem_we, bus.mem_addr} !== {2'b10, 8'h00}) begin
      miscompares++; $display("FAIL chk_acc got cs=%b we=%b addr=%h exp 1 0 00", bus.mem_cs, bus.mem_we, bus.mem_addr);
    end
    @(negedge clk);
    vectors++;
    if (bus.mem_we !== 1'b0) begin
      miscompares++; $display("FAIL chk_we got %b exp 0", bus.mem_we);
    end
    @(negedge clk);
    vectors++;
    if ({bus.host_ack, bus.host_rdata, bus.cpu_ack} !== {1'b1, 8'h12, 1'b0}) begin
      miscompares++; $display("FAIL chk_ack got ack=%b rdata=%h cpu_ack=%b exp 1 12 0", bus.host_ack, bus.host_rdata, bus.cpu_ack);
    end
    bus.host_req = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.host_ack, bus.host_ptr, bus.host_rdata} !== {1'b0, 8'h01, 8'h12}) begin
      miscompares++; $display("FAIL chk_done got ack=%b ptr=%h rdata=%h exp 0 01 12", bus.host_ack, bus.host_ptr, bus.host_rdata);
    end
  endtask

  task automatic test_run_mode;
    bus.cpustate = 2'b11;
    preload(8'h02, 8'h56);
    bus.cpu_addr = 8'h02; bus.cpu_read = 1'b1;
    #1;
    vectors++;
    if (bus.cpu_stall !== 1'b1) begin
      miscompares++; $display("FAIL run_stall0 got %b exp 1", bus.cpu_stall);
    end
    @(negedge clk);
    vectors++;
    if ({bus.cpu_stall, bus.mem_cs, bus.mem_we, bus.mem_addr} !== {3'b110, 8'h02}) begin
      miscompares++; $display("FAIL run_acc got stall=%b cs=%b we=%b addr=%h exp 1 1 0 02",
        bus.cpu_stall, bus.mem_cs, bus.mem_we, bus.mem_addr);
    end
    @(negedge clk);
    vectors++;
    if ({bus.cpu_stall, bus.cpu_ack} !== 2'b10) begin
      miscompares++; $display("FAIL run_lat got stall=%b ack=%b exp 1 0", bus.cpu_stall, bus.cpu_ack);
    end
    @(negedge clk);
    vectors++;
    if ({bus.cpu_ack, bus.cpu_stall, bus.cpu_rdata} !== {2'b10, 8'h56}) begin
      miscompares++; $display("FAIL run_ack got ack=%b stall=%b rdata=%h exp 1 0 56", bus.cpu_ack, bus.cpu_stall, bus.cpu_rdata);
    end
    bus.cpu_read = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.cpu_ack, bus.cpu_stall, bus.cpu_rdata, bus.host_ack} !== {2'b00, 8'h56, 1'b0}) begin
      miscompares++; $display("FAIL run_hold got ack=%b stall=%b rdata=%h hack=%b exp 0 0 56 0",
        bus.cpu_ack, bus.cpu_stall, bus.cpu_rdata, bus.host_ack);
    end
    // read and write together: the write is performed
    bus.cpu_addr = 8'h05; bus.cpu_wdata = 8'hAA; bus.cpu_read = 1'b1; bus.cpu_write = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.mem_we, bus.mem_din} !== {1'b1, 8'hAA}) begin
      miscompares++; $display("FAIL run_wwins got we=%b din=%h exp 1 aa", bus.mem_we, bus.mem_din);
    end
    repeat (2) @(negedge clk);
    bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
    @(negedge clk);
    vectors++;
    if (ram[5] !== 8'hAA) begin
      miscompares++; $display("FAIL run_wram got %h exp aa", ram[5]);
    end
  endtask

  task automatic test_ownership;
    bus.cpustate = 2'b11; bus.host_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.mem_cs, bus.host_ack} !== 2'b00) begin
        miscompares++; $display("FAIL own_host%0d got cs=%b ack=%b exp 0 0", i, bus.mem_cs, bus.host_ack);
      end
    end
    bus.host_req = 1'b0;
    bus.cpustate = 2'b00; bus.cpu_write = 1'b1; bus.cpu_addr = 8'h07; bus.cpu_wdata = 8'h99;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.mem_cs, bus.cpu_stall, bus.cpu_ack} !== 3'b010) begin
        miscompares++; $display("FAIL own_cpu%0d got cs=%b stall=%b ack=%b exp 0 1 0", i, bus.mem_cs, bus.cpu_stall, bus.cpu_ack);
      end
    end
    bus.cpu_write = 1'b0;
    vectors++;
    if (ram[7] !== 8'h00) begin
      miscompares++; $display("FAIL own_ram got %h exp 00", ram[7]);
    end
    bus.cpustate = 2'b10; bus.host_req = 1'b1; bus.cpu_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.mem_cs, bus.host_ack, bus.cpu_ack} !== 3'b000) begin
        miscompares++; $display("FAIL own_none%0d got cs=%b hack=%b cack=%b exp 0 0 0", i, bus.mem_cs, bus.host_ack, bus.cpu_ack);
      end
    end
    bus.host_req = 1'b0; bus.cpu_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mode_switch;
    // host_ptr is 1 here (left by the CHECK read)
    bus.cpustate = 2'b00; bus.host_wdata = 8'h77; bus.host_req = 1'b1;
    bus.cpu_addr = 8'h02; bus.cpu_read = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.mem_cs, bus.mem_we, bus.mem_addr} !== {2'b11, 8'h01}) begin
      miscompares++; $display("FAIL sw_acc got cs=%b we=%b addr=%h exp 1 1 01", bus.mem_cs, bus.mem_we, bus.mem_addr);
    end
    bus.cpustate = 2'b11;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({bus.host_ack, bus.cpu_ack} !== 2'b10) begin
      miscompares++; $display("FAIL sw_hack got hack=%b cack=%b exp 1 0", bus.host_ack, bus.cpu_ack);
    end
    bus.host_req = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.host_ptr, bus.mem_cs, bus.mem_we, bus.mem_addr, ram[1]} !== {8'h02, 2'b10, 8'h02, 8'h77}) begin
      miscompares++; $display("FAIL sw_cpu_acc got ptr=%h cs=%b we=%b addr=%h ram1=%h exp 02 1 0 02 77",
        bus.host_ptr, bus.mem_cs, bus.mem_we, bus.mem_addr, ram[1]);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.cpu_ack, bus.cpu_rdata} !== {1'b1, 8'h56}) begin
      miscompares++; $display("FAIL sw_cack got ack=%b rdata=%h exp 1 56", bus.cpu_ack, bus.cpu_rdata);
    end
    bus.cpu_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ptr_wrap;
    bus.cpustate = 2'b00;
    clr_ptr();
    for (int i = 0; i < 255; i++) begin
      bus.host_wdata = 8'(i); bus.host_req = 1'b1;
      repeat (3) @(negedge clk);
      bus.host_req = 1'b0;
      @(negedge clk);
    end
    vectors++;
    if (bus.host_ptr !== 8'hFF) begin
      miscompares++; $display("FAIL wrap_pre got %h exp ff", bus.host_ptr);
    end
    bus.host_wdata = 8'h5A; bus.host_req = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.mem_addr !== 8'hFF) begin
      miscompares++; $display("FAIL wrap_addr got %h exp ff", bus.mem_addr);
    end
    repeat (2) @(negedge clk);
    bus.host_req = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.host_ptr, ram[255]} !== {8'h00, 8'h5A}) begin
      miscompares++; $display("FAIL wrap_ptr got ptr=%h ram=%h exp 00 5a", bus.host_ptr, ram[255]);
    end
    // clear asserted in the ack cycle wins over the increment
    bus.host_wdata = 8'h11; bus.host_req = 1'b1;
    repeat (3) @(negedge clk);
    bus.host_req = 1'b0; bus.host_ptr_clr = 1'b1;
    @(negedge clk);
    bus.host_ptr_clr = 1'b0;
    vectors++;
    if (bus.host_ptr !== 8'h00) begin
      miscompares++; $display("FAIL clr_prio got %h exp 00", bus.host_ptr);
    end
  endtask

  task automatic test_reset_mid;
    bus.cpustate = 2'b00; bus.host_wdata = 8'hC3; bus.host_req = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.mem_we !== 1'b1) begin
      miscompares++; $display("FAIL rst_pre got we=%b exp 1", bus.mem_we);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({bus.mem_cs, bus.mem_we, bus.mem_addr, bus.mem_din, bus.cpu_ack, bus.host_ack,
         bus.cpu_rdata, bus.host_rdata, bus.host_ptr} !== 44'h0) begin
      miscompares++; $display("FAIL rst_mid got cs=%b we=%b din=%h crd=%h hrd=%h exp all 0",
        bus.mem_cs, bus.mem_we, bus.mem_din, bus.cpu_rdata, bus.host_rdata);
    end
    bus.host_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.host_ack, bus.mem_cs} !== 2'b00) begin
        miscompares++; $display("FAIL rst_noack%0d got ack=%b cs=%b exp 0 0", i, bus.host_ack, bus.mem_cs);
      end
    end
    vectors++;
    if (ram[0] !== 8'h11) begin
      miscompares++; $display("FAIL rst_ram got %h exp 11", ram[0]);
    end
  endtask

  initial begin
    test_reset();
    test_in_mode();
    test_check_mode();
    test_run_mode();
    test_ownership();
    test_mode_switch();
    test_ptr_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
